// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : adder_pkg

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell used by the serial adder datapath.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic c
);

  // Sum and carry of three input bits.
  always_comb begin
    s = a ^ b ^ ci;
    c = (a & b) | (a & ci) | (b & ci);
  end

endmodule : fa

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds a + b + ci one bit per cycle through a single
// full-adder cell with a registered carry. Result and carry-out are registered
// and only change on the completion edge.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_cr;
  logic             r_co;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_sr_nxt;

  fa u_fa (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .ci (r_cr),
    .s  (w_s),
    .c  (w_c)
  );

  // Next-state decode; DONE samples start on its exit edge so a held start
  // re-arms with no idle gap (period WIDTH+1).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result shift: new sum bit enters at the MSB (written this way so WIDTH=1 needs no slice).
  always_comb begin
    w_sr_nxt            = r_sr >> 1;
    w_sr_nxt[WIDTH-1]   = w_s;
  end

  // State register, operand/result shifters, bit counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sr    <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cr    <= 1'b0;
      r_co    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_last;
      if (w_accept) begin
        r_sa  <= a;
        r_sb  <= b;
        r_cr  <= ci;
        r_cnt <= '0;
      end else if (r_state == ST_RUN) begin
        r_sr  <= w_sr_nxt;
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_cr  <= w_c;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum <= w_sr_nxt;
          r_co  <= w_c;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign co   = r_co;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=3 against an
// arithmetic reference (a + b + ci) with latency expectations.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       start3, ci3, busy3, done3, co3;
  logic [2:0] a3, b3, sum3;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [8:0] exp_last8 = '0;
  logic [3:0] exp_last3 = '0;

  logic [7:0] ha [0:27];
  logic [7:0] hb [0:27];
  logic       hc [0:27];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .ci(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .ci(ci3),
    .busy(busy3), .done(done3), .sum(sum3), .co(co3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One WIDTH=8 operation; called right after a negedge, returns right after a negedge.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tci);
    logic [8:0] exp;
    int unsigned lat;
    bit got;
    exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tci};
    a8 = ta; b8 = tb; ci8 = tci; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("busy_acc8", busy8, 1);
    lat = 99; got = 0;
    for (int k = 1; k <= 12 && !got; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      @(negedge clk);
      if (done8) begin
        got = 1; lat = k;
      end else begin
        chk("hold8", {co8, sum8}, exp_last8);
        chk("busy_run8", busy8, 1);
      end
    end
    chk("lat8", lat, 8);
    chk("res8", {co8, sum8}, exp);
    exp_last8 = exp;
    @(negedge clk);
    chk("done_1cyc8", done8, 0);
    chk("busy_end8", busy8, 0);
    chk("hold_after8", {co8, sum8}, exp_last8);
  endtask

  // One WIDTH=3 operation, same timing contract.
  task automatic run3(input logic [2:0] ta, input logic [2:0] tb, input logic tci);
    logic [3:0] exp;
    int unsigned lat;
    bit got;
    exp = {1'b0, ta} + {1'b0, tb} + {3'd0, tci};
    a3 = ta; b3 = tb; ci3 = tci; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 99; got = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      a3 = 3'($urandom); b3 = 3'($urandom); ci3 = 1'($urandom);
      @(negedge clk);
      if (done3) begin
        got = 1; lat = k;
      end else begin
        chk("hold3", {co3, sum3}, exp_last3);
      end
    end
    chk("lat3", lat, 3);
    chk("res3", {co3, sum3}, exp);
    exp_last3 = exp;
    @(negedge clk);
    chk("done_1cyc3", done3, 0);
  endtask

  initial begin
    int unsigned ndone;
    bit de;
    rst_n = 1'b0;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
    start3 = 1'b1; a3 = 3'h7;  b3 = 3'h7;  ci3 = 1'b1;

    // Reset held with start high.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_res",  {co8, sum8}, 0);
    chk("rst_busy3", busy3, 0);
    start8 = 1'b0; start3 = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy8, 0);
    chk("idle_done", done8, 0);
    chk("idle_res",  {co8, sum8}, 0);

    // Directed WIDTH=8 cases.
    run8(8'h3C, 8'h5A, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'hFF, 8'hFF, 1'b1);
    run8(8'h00, 8'h00, 1'b0);

    // Randomized WIDTH=8 operations.
    for (int i = 0; i < 16; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom));

    // Back-to-back with start held and operands toggling every cycle.
    for (int i = 0; i < 28; i++) begin
      ha[i] = 8'($urandom); hb[i] = 8'($urandom); hc[i] = 1'($urandom);
    end
    a8 = ha[0]; b8 = hb[0]; ci8 = hc[0]; start8 = 1'b1;
    ndone = 0;
    for (int e = 0; e <= 28; e++) begin
      @(negedge clk);
      de = (e == 8) || (e == 17) || (e == 26);
      chk("b2b_done", done8, de);
      chk("b2b_busy", busy8, (e <= 26));
      if (done8) ndone++;
      if (de) exp_last8 = {1'b0, ha[e-8]} + {1'b0, hb[e-8]} + {8'd0, hc[e-8]};
      chk("b2b_res", {co8, sum8}, exp_last8);
      if (e + 1 <= 27) begin
        a8 = ha[e+1]; b8 = hb[e+1]; ci8 = hc[e+1];
      end
      start8 = (e + 1 <= 26);
    end
    chk("b2b_ndone", ndone, 3);

    // Reset after bit 4 of an operation aborts it.
    a8 = 8'hA5; b8 = 8'h5B; ci8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_res",  {co8, sum8}, 0);
    exp_last8 = '0;
    exp_last3 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    chk("abort_res_hold", {co8, sum8}, 0);
    run8(8'h01, 8'h02, 1'b1);

    // WIDTH=3 exhaustive.
    for (int unsigned v = 0; v < 128; v++)
      run3(3'(v >> 4), 3'(v >> 1), 1'(v));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_serial_adder
